// File: rtl/adder_pkg.sv
// Shared constants and types for the 16-bit registered ripple-carry adder.
package adder_pkg;

    localparam int ADD_WIDTH = 16;

    typedef logic [ADD_WIDTH-1:0] word_t;

endpackage : adder_pkg

// File: rtl/fulladd_16_if.sv
// Operand/result bundle for fulladd_16: the master drives operands, the slave returns the sum.
interface fulladd_16_if;
    import adder_pkg::*;

    word_t a;
    word_t b;
    logic  c_in;
    word_t s;
    logic  c_out;

    modport master (
        output a,
        output b,
        output c_in,
        input  s,
        input  c_out
    );

    modport slave (
        input  a,
        input  b,
        input  c_in,
        output s,
        output c_out
    );

endinterface : fulladd_16_if

// File: rtl/fa_cell.sv
// One-bit full adder; chained through its carry to build the ripple adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ ci;
    assign co       = (a & b) | (ci & half_sum);

endmodule : fa_cell

// File: rtl/fulladd_16.sv
// Unsigned WIDTH-bit adder with carry-in/out: ripple-carry core, result registered once.
module fulladd_16
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    fulladd_16_if.slave   bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_n;

    assign carry[0] = bus.c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (carry[i]),
            .s  (sum_n[i]),
            .co (carry[i+1])
        );
    end

    // Reset discards the sum computed at that edge rather than holding it over.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.s     <= '0;
            bus.c_out <= 1'b0;
        end else begin
            bus.s     <= sum_n;
            bus.c_out <= carry[WIDTH];
        end
    end

endmodule : fulladd_16

// File: tb/tb_fulladd_16.sv
// Self-checking bench for fulladd_16: directed vector table, mid-stream reset and a scoreboarded sweep.
module tb_fulladd_16;
    import adder_pkg::*;

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] a;
        logic [15:0] b;
        logic        c_in;
        logic [15:0] s;
        logic        c_out;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [16:0] expected_q[$];
    vec_t        vecs[$];

    fulladd_16_if bus ();

    fulladd_16 #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t make_vec(string name, logic r, logic [15:0] a, logic [15:0] b,
                                      logic ci, logic [15:0] s, logic co);
        vec_t v;
        v.name  = name;
        v.rst   = r;
        v.a     = a;
        v.b     = b;
        v.c_in  = ci;
        v.s     = s;
        v.c_out = co;
        return v;
    endfunction

    // Drive one operand set away from the clock edge and record the result due after the edge.
    task automatic applyStimulus(input logic r, input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci, input logic [16:0] expected);
        @(negedge clk);
        rst      = r;
        bus.a    = av;
        bus.b    = bv;
        bus.c_in = ci;
        expected_q.push_back(expected);
    endtask

    task automatic checkOutput(input string name);
        logic [16:0] exp_v;
        logic [16:0] got_v;
        @(posedge clk);
        #1;
        checks++;
        got_v = {bus.c_out, bus.s};
        if (expected_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got c_out=%b s=%h", name, bus.c_out, bus.s);
        end else begin
            exp_v = expected_q.pop_front();
            if (got_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL %s: got c_out=%b s=%h, expected c_out=%b s=%h",
                         name, got_v[16], got_v[15:0], exp_v[16], exp_v[15:0]);
            end
        end
    endtask

    initial begin
        logic [15:0] sa;
        logic [15:0] sb;
        logic        sc;
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        bus.a    = '0;
        bus.b    = '0;
        bus.c_in = 1'b0;

        vecs.push_back(make_vec("reset_edge1", 1'b1, 16'h1234, 16'h1111, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(make_vec("reset_edge2", 1'b1, 16'h1234, 16'h1111, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(make_vec("zero_cin",    1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0));
        vecs.push_back(make_vec("full_ripple", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1));
        vecs.push_back(make_vec("maximum",     1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1));
        vecs.push_back(make_vec("plain_5555",  1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0));
        vecs.push_back(make_vec("wrap_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1));
        vecs.push_back(make_vec("all_zero",    1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(make_vec("alt_bits",    1'b0, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1));
        vecs.push_back(make_vec("alt_no_cin",  1'b0, 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0));
        vecs.push_back(make_vec("msb_carry",   1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1));
        vecs.push_back(make_vec("mixed",       1'b0, 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].c_in, {vecs[i].c_out, vecs[i].s});
            checkOutput(vecs[i].name);
        end

        // Reset pulsed for one cycle while operands stay at 0x8000+0x8000.
        applyStimulus(1'b0, 16'h8000, 16'h8000, 1'b0, 17'h10000);
        checkOutput("midrst_before");
        applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b0, 17'h00000);
        checkOutput("midrst_pulse");
        applyStimulus(1'b0, 16'h8000, 16'h8000, 1'b0, 17'h10000);
        checkOutput("midrst_after");

        // Sweep across the 0xFFFF boundary: c_in every cycle, a every 2, b every 4.
        sa = 16'hFFC0;
        sb = 16'h0020;
        sc = 1'b0;
        for (int cyc = 0; cyc < 128; cyc++) begin
            applyStimulus(1'b0, sa, sb, sc, {1'b0, sa} + {1'b0, sb} + {16'h0000, sc});
            checkOutput($sformatf("sweep_%0d", cyc));
            sc = ~sc;
            if (cyc % 2 == 1) sa = sa + 16'd1;
            if (cyc % 4 == 3) sb = sb + 16'd1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fulladd_16
